rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 11 +
 rtl/rom_arb_rr2.sv | 20 ++
 rtl/rom_arbiter.sv | 123 ++++++++++++
 tb/tb_rom_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the two-requester ROM read arbiter.
package rom_arb_pkg;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/rom_arb_rr2.sv
// Two-way round-robin winner select: ptr is the index granted last time,
// so on a tie the other requester wins.
module rom_arb_rr2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  // Lone requester always wins; a tie goes to whoever was not granted last.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read requesters onto one external combinational ROM with a
// fixed IDLE -> ACCESS -> RESP sequence (one read per three cycles).
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        vld,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rom_cs,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [1:0]          win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          vld_q, vld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d;
  logic [1:0]          win_s;

  rom_arb_rr2 u_rr2 (
    .req (req),
    .ptr (ptr_q),
    .win (win_s)
  );

  // Next-state and registered-output logic; every output is a register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = ACCESS;
          win_d   = win_s;
          ptr_d   = win_s[1];
          addr_d  = win_s[1] ? addr1 : addr0;
          gnt_d   = win_s;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        gnt_d   = 2'b00;
        cs_d    = 1'b0;
        rdata_d = rom_data;
        vld_d   = win_q;
        busy_d  = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        vld_d   = 2'b00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        vld_d   = 2'b00;
        cs_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      win_q   <= 2'b00;
      addr_q  <= '0;
      gnt_q   <= 2'b00;
      vld_q   <= 2'b00;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
    end
  end

  assign gnt      = gnt_q;
  assign vld      = vld_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign rom_cs   = cs_q;
  assign rom_rd   = cs_q;
  assign rom_addr = addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter against a grant-schedule model.
module tb_rom_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [AW-1:0] addr0, addr1;
  logic [1:0]    gnt, vld;
  logic [DW-1:0] rdata;
  logic          busy, rom_cs, rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rom [0:7];

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .vld(vld), .rdata(rdata), .busy(busy),
    .rom_cs(rom_cs), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Model: the edge index of the most recent grant fixes every output.
  int            e_idx = 0;
  int            g_idx = -10;
  logic          m_last = 1'b1;
  logic [1:0]    m_win = 2'b00;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    x_gnt, x_vld;
  logic          x_busy, x_cs;

  logic       pg_en, pv_en, pr_en, pb_en, pc_en;
  logic [1:0] pg, pv;
  logic [7:0] pr;
  logic       pb, pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0h want=%0h", name, e_idx, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", {30'd0, gnt}, {30'd0, x_gnt});
      check("vld", {30'd0, vld}, {30'd0, x_vld});
      check("rdata", {24'd0, rdata}, {24'd0, m_rdata});
      check("busy", {31'd0, busy}, {31'd0, x_busy});
      check("rom_cs", {31'd0, rom_cs}, {31'd0, x_cs});
      check("rom_rd", {31'd0, rom_rd}, {31'd0, x_cs});
      check("rom_addr", {29'd0, rom_addr}, {29'd0, m_addr});
      check("exclusive", {31'd0, ($countones(gnt) <= 1) && ($countones(vld) <= 1) &&
                           !((gnt != 2'b00) && (vld != 2'b00))}, 32'd1);
      if (pg_en) check("pin_gnt", {30'd0, gnt}, {30'd0, pg});
      if (pv_en) check("pin_vld", {30'd0, vld}, {30'd0, pv});
      if (pr_en) check("pin_rdata", {24'd0, rdata}, {24'd0, pr});
      if (pb_en) check("pin_busy", {31'd0, busy}, {31'd0, pb});
      if (pc_en) check("pin_rom_cs", {31'd0, rom_cs}, {31'd0, pc});
    end
  end

  task automatic model(input logic r, input logic [1:0] rq, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    e_idx++;
    if (r) begin
      g_idx = -10; m_last = 1'b1; m_win = 2'b00; m_addr = '0; m_rdata = '0;
    end else if (e_idx == g_idx + 1) begin
      m_rdata = rom[m_addr];
    end else if (e_idx >= g_idx + 3 && rq != 2'b00) begin
      m_win  = (rq == 2'b11) ? (m_last ? 2'b01 : 2'b10) : rq;
      m_last = m_win[1];
      m_addr = m_win[1] ? a1 : a0;
      g_idx  = e_idx;
    end
    x_gnt  = (e_idx == g_idx) ? m_win : 2'b00;
    x_vld  = (e_idx == g_idx + 1) ? m_win : 2'b00;
    x_busy = (e_idx == g_idx) || (e_idx == g_idx + 1);
    x_cs   = (e_idx == g_idx);
  endtask

  // Applies inputs for the coming edge; pins set after this call refer to that edge.
  task automatic step(input logic r, input logic [1:0] rq, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(negedge clk);
    #2;
    pg_en = 1'b0; pv_en = 1'b0; pr_en = 1'b0; pb_en = 1'b0; pc_en = 1'b0;
    rst = r; req = rq; addr0 = a0; addr1 = a1;
    model(r, rq, a0, a1);
    chk_en = 1'b1;
  endtask

  task automatic pin_g(input logic [1:0] v); pg_en = 1'b1; pg = v; endtask
  task automatic pin_v(input logic [1:0] v); pv_en = 1'b1; pv = v; endtask
  task automatic pin_r(input logic [7:0] v); pr_en = 1'b1; pr = v; endtask
  task automatic pin_b(input logic v);       pb_en = 1'b1; pb = v; endtask
  task automatic pin_c(input logic v);       pc_en = 1'b1; pc = v; endtask

  task automatic do_reset();
    step(1'b1, 2'b00, 3'd0, 3'd0);
    step(1'b1, 2'b00, 3'd0, 3'd0);
  endtask

  initial begin
    rom[0] = 8'd22; rom[1] = 8'd2;  rom[2] = 8'd12; rom[3] = 8'd4;
    rom[4] = 8'd14; rom[5] = 8'd13; rom[6] = 8'd11; rom[7] = 8'd44;
    pg_en = 1'b0; pv_en = 1'b0; pr_en = 1'b0; pb_en = 1'b0; pc_en = 1'b0;
    pg = 2'b00; pv = 2'b00; pr = 8'd0; pb = 1'b0; pc = 1'b0;
    rst = 1'b1; req = 2'b00; addr0 = '0; addr1 = '0;

    do_reset();
    pin_g(2'b00); pin_v(2'b00); pin_r(8'd0); pin_b(1'b0); pin_c(1'b0);

    // Single read of address 7.
    step(1'b0, 2'b01, 3'd7, 3'd0); pin_g(2'b01); pin_b(1'b1); pin_c(1'b1);
    step(1'b0, 2'b00, 3'd7, 3'd0); pin_v(2'b01); pin_r(8'd44); pin_b(1'b1);
    step(1'b0, 2'b00, 3'd7, 3'd0); pin_b(1'b0); pin_v(2'b00);

    // Tie after reset: requester 0 first, then requester 1, vld three cycles apart.
    do_reset();
    step(1'b0, 2'b11, 3'd3, 3'd5); pin_g(2'b01);
    step(1'b0, 2'b11, 3'd3, 3'd5); pin_v(2'b01); pin_r(8'd4);
    step(1'b0, 2'b11, 3'd3, 3'd5); pin_b(1'b0); pin_g(2'b00);
    step(1'b0, 2'b10, 3'd3, 3'd5); pin_g(2'b10);
    step(1'b0, 2'b00, 3'd3, 3'd5); pin_v(2'b10); pin_r(8'd13);

    // Sustained contention alternates grants.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 2'b11, 3'd2, 3'd4);
      if (i % 3 == 0) pin_g(((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Address change during ACCESS is ignored.
    do_reset();
    step(1'b0, 2'b01, 3'd0, 3'd0); pin_g(2'b01);
    step(1'b0, 2'b00, 3'd6, 3'd0); pin_v(2'b01); pin_r(8'd22);
    step(1'b0, 2'b00, 3'd6, 3'd0);

    // Reset during ACCESS aborts without a late vld.
    step(1'b0, 2'b01, 3'd1, 3'd0); pin_g(2'b01); pin_c(1'b1);
    step(1'b1, 2'b00, 3'd1, 3'd0); pin_v(2'b00); pin_r(8'd0); pin_c(1'b0); pin_b(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 3'd1, 3'd0); pin_v(2'b00);
    end

    // Idle stays quiet.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00, 3'd5, 3'd6);
      pin_g(2'b00); pin_v(2'b00); pin_b(1'b0); pin_c(1'b0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
